// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, scan-engine state encoding and the divider
//               width helper for the parametrised register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int unsigned c_DEFAULT_DATA_W = 8;
    localparam int unsigned c_DEFAULT_ADDR_W = 3;

    // Scan engine is either parked (index/data held) or stepping.
    typedef enum logic [0:0] {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_t;

    // Counter width able to hold 0..n-1; never narrower than one bit so a
    // divide-by-one still gets a legal (constant-zero) counter.
    function automatic int unsigned f_cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scan.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scan
// Description : Debug scan engine. Divides the clock, walks the register
//               index and captures the value of each newly presented
//               register together with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scan
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = c_DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = c_DEFAULT_ADDR_W,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_scan_en,
    input  logic [DATA_W-1:0] i_next_data,   // forwarded value of o_next_idx
    output logic [ADDR_W-1:0] o_next_idx,    // index the next step moves to
    output logic [ADDR_W-1:0] o_scan_idx,
    output logic [DATA_W-1:0] o_scan_data,
    output logic              o_scan_valid
);

    localparam int unsigned             c_DIV_W    = f_cnt_width(SCAN_DIV);
    localparam logic [c_DIV_W-1:0]      c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);

    scan_state_t         r_state;
    scan_state_t         w_state_next;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_DIV_W-1:0]  w_div_next;
    logic                w_step;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;

    // Index wraps naturally from DEPTH-1 to 0 through the ADDR_W-bit add.
    assign o_next_idx   = r_idx + ADDR_W'(1);
    assign o_scan_idx   = r_idx;
    assign o_scan_data  = r_data;
    assign o_scan_valid = r_valid;

    // State register for the idle/run scan machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus divider control; enabling counts on the very same edge.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = '0;
        w_step       = 1'b0;
        case (r_state)
            SCAN_IDLE: if (i_scan_en)  w_state_next = SCAN_RUN;
            SCAN_RUN:  if (!i_scan_en) w_state_next = SCAN_IDLE;
        endcase
        if (i_scan_en) begin
            w_step     = (r_div == c_DIV_LAST);
            w_div_next = w_step ? '0 : (r_div + c_DIV_W'(1));
        end
    end

    // Divider, index and captured data; data refreshes only on a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_div   <= w_div_next;
            r_valid <= w_step;
            if (w_step) begin
                r_idx  <= o_next_idx;
                r_data <= i_next_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : param_register_file
// Description : 2^ADDR_W x DATA_W register file, one synchronous write port,
//               two combinational read ports, optional hardwired-zero r0,
//               optional write-to-read bypass and a built-in debug scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module param_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = c_DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = c_DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b0,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iWE,
    input  logic [ADDR_W-1:0] iWA,
    input  logic [DATA_W-1:0] iWD,
    input  logic [ADDR_W-1:0] iRA1,
    input  logic [ADDR_W-1:0] iRA2,
    output logic [DATA_W-1:0] oRD1,
    output logic [DATA_W-1:0] oRD2,
    input  logic              iScanEn,
    output logic [ADDR_W-1:0] oScanIdx,
    output logic [DATA_W-1:0] oScanData,
    output logic              oScanValid
);

    localparam int unsigned c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [c_DEPTH];
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [ADDR_W-1:0] w_scan_idx_next;
    logic [DATA_W-1:0] w_scan_rd;

    // A write to register 0 is discarded when it is hardwired to zero.
    assign w_wr_ok = iWE && !(ZERO_REG && (iWA == '0));

    // Storage: reset clears every entry, otherwise one write per edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[iWA] <= iWD;
        end
    end

    // Read port 1: zero register wins over bypass, bypass over storage.
    always_comb begin
        w_rd1 = r_regs[iRA1];
        if (ZERO_REG && (iRA1 == '0)) begin
            w_rd1 = '0;
        end else if (BYPASS && w_wr_ok && (iRA1 == iWA)) begin
            w_rd1 = iWD;
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        w_rd2 = r_regs[iRA2];
        if (ZERO_REG && (iRA2 == '0)) begin
            w_rd2 = '0;
        end else if (BYPASS && w_wr_ok && (iRA2 == iWA)) begin
            w_rd2 = iWD;
        end
    end

    // Scan read port always forwards this edge's write so the captured value
    // matches the register contents after the edge, independent of BYPASS.
    always_comb begin
        w_scan_rd = r_regs[w_scan_idx_next];
        if (ZERO_REG && (w_scan_idx_next == '0)) begin
            w_scan_rd = '0;
        end else if (w_wr_ok && (iWA == w_scan_idx_next)) begin
            w_scan_rd = iWD;
        end
    end

    assign oRD1 = w_rd1;
    assign oRD2 = w_rd2;

    regfile_scan #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk          (iCLK),
        .rst_n        (iRST_N),
        .i_scan_en    (iScanEn),
        .i_next_data  (w_scan_rd),
        .o_next_idx   (w_scan_idx_next),
        .o_scan_idx   (oScanIdx),
        .o_scan_data  (oScanData),
        .o_scan_valid (oScanValid)
    );

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_register_file
// Description : Self-checking bench for param_register_file. Three instances
//               share stimulus: A (ZERO_REG=1, BYPASS=1, SCAN_DIV=4),
//               B (ZERO_REG=0, BYPASS=0, SCAN_DIV=4),
//               C (ZERO_REG=1, BYPASS=0, SCAN_DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       scan_en;

    logic [7:0] rd1_a, rd2_a, sdata_a;
    logic [2:0] sidx_a;
    logic       svalid_a;
    logic [7:0] rd1_b, rd2_b, sdata_b;
    logic [2:0] sidx_b;
    logic       svalid_b;
    logic [7:0] rd1_c, rd2_c, sdata_c;
    logic [2:0] sidx_c;
    logic       svalid_c;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    param_register_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1), .SCAN_DIV(4)) u_a (
        .iCLK(clk), .iRST_N(rst_n), .iWE(we), .iWA(wa), .iWD(wd), .iRA1(ra1), .iRA2(ra2),
        .oRD1(rd1_a), .oRD2(rd2_a), .iScanEn(scan_en), .oScanIdx(sidx_a),
        .oScanData(sdata_a), .oScanValid(svalid_a));

    param_register_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0), .SCAN_DIV(4)) u_b (
        .iCLK(clk), .iRST_N(rst_n), .iWE(we), .iWA(wa), .iWD(wd), .iRA1(ra1), .iRA2(ra2),
        .oRD1(rd1_b), .oRD2(rd2_b), .iScanEn(scan_en), .oScanIdx(sidx_b),
        .oScanData(sdata_b), .oScanValid(svalid_b));

    param_register_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0), .SCAN_DIV(1)) u_c (
        .iCLK(clk), .iRST_N(rst_n), .iWE(we), .iWA(wa), .iWD(wd), .iRA1(ra1), .iRA2(ra2),
        .oRD1(rd1_c), .oRD2(rd2_c), .iScanEn(scan_en), .oScanIdx(sidx_c),
        .oScanData(sdata_c), .oScanValid(svalid_c));

    // Hold reset for two cycles and release it on a falling edge.
    task automatic do_reset();
        rst_n   = 1'b0;
        we      = 1'b0;
        scan_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One write, active on the rising edge between two falling edges.
    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; scan_en = 1'b0;
        #23;
        @(negedge clk);
        rst_n = 1'b1; ra1 = 3'd5; ra2 = 3'd7;
        #1;
        n_checks++; if (rd1_a !== 8'h00) $display("FAIL reset_rd1 actual=%h required=00", rd1_a); else n_pass++;
        n_checks++; if (rd2_a !== 8'h00) $display("FAIL reset_rd2 actual=%h required=00", rd2_a); else n_pass++;
        n_checks++; if (rd1_b !== 8'h00) $display("FAIL reset_rd1_b actual=%h required=00", rd1_b); else n_pass++;
        n_checks++; if (sidx_a !== 3'd0) $display("FAIL reset_scan_idx actual=%0d required=0", sidx_a); else n_pass++;
        n_checks++; if (sdata_a !== 8'h00) $display("FAIL reset_scan_data actual=%h required=00", sdata_a); else n_pass++;
        n_checks++; if (svalid_a !== 1'b0) $display("FAIL reset_scan_valid actual=%b required=0", svalid_a); else n_pass++;
    endtask

    task automatic test_zero_reg();
        do_reset();
        @(negedge clk);
        we = 1'b1; wa = 3'd0; wd = 8'hAA; ra1 = 3'd0;
        #1;
        n_checks++; if (rd1_a !== 8'h00) $display("FAIL zero_bypass_a actual=%h required=00", rd1_a); else n_pass++;
        n_checks++; if (rd1_b !== 8'h00) $display("FAIL zero_prewrite_b actual=%h required=00", rd1_b); else n_pass++;
        @(negedge clk);
        we = 1'b0;
        #1;
        n_checks++; if (rd1_a !== 8'h00) $display("FAIL zero_write_a actual=%h required=00", rd1_a); else n_pass++;
        n_checks++; if (rd1_b !== 8'hAA) $display("FAIL zero_write_b actual=%h required=aa", rd1_b); else n_pass++;
    endtask

    task automatic test_bypass();
        do_reset();
        write_reg(3'd3, 8'h11);
        we = 1'b1; wa = 3'd3; wd = 8'h5C; ra1 = 3'd3; ra2 = 3'd3;
        #1;
        n_checks++; if (rd1_a !== 8'h5C) $display("FAIL bypass_on_rd1 actual=%h required=5c", rd1_a); else n_pass++;
        n_checks++; if (rd2_a !== 8'h5C) $display("FAIL bypass_on_rd2 actual=%h required=5c", rd2_a); else n_pass++;
        n_checks++; if (rd1_b !== 8'h11) $display("FAIL bypass_off_rd1 actual=%h required=11", rd1_b); else n_pass++;
        n_checks++; if (rd2_b !== 8'h11) $display("FAIL bypass_off_rd2 actual=%h required=11", rd2_b); else n_pass++;
        ra2 = 3'd0;
        #1;
        n_checks++; if (rd2_a !== 8'h00) $display("FAIL bypass_r0_rd2 actual=%h required=00", rd2_a); else n_pass++;
        @(negedge clk);
        we = 1'b0;
        #1;
        n_checks++; if (rd1_a !== 8'h5C) $display("FAIL bypass_after_a actual=%h required=5c", rd1_a); else n_pass++;
        n_checks++; if (rd1_b !== 8'h5C) $display("FAIL bypass_after_b actual=%h required=5c", rd1_b); else n_pass++;
    endtask

    task automatic test_scan_sweep();
        exp_t e;
        int   cyc;
        int   last;
        do_reset();
        for (int i = 1; i < 8; i++) write_reg(3'(i), 8'(i * 16));
        for (int k = 1; k <= 9; k++) begin
            e.idx  = 3'(k % 8);
            e.data = ((k % 8) == 0) ? 8'h00 : 8'((k % 8) * 16);
            sb_q.push_back(e);
        end
        scan_en = 1'b1;
        cyc = 0; last = 0;
        for (int t = 0; t < 60 && sb_q.size() > 0; t++) begin
            @(negedge clk);
            #1;
            cyc++;
            n_checks++; if (svalid_c !== 1'b1) $display("FAIL sweep_div1_valid actual=%b required=1", svalid_c); else n_pass++;
            if (svalid_a === 1'b1) begin
                e = sb_q.pop_front();
                n_checks++; if (sidx_a !== e.idx) $display("FAIL sweep_idx actual=%0d required=%0d", sidx_a, e.idx); else n_pass++;
                n_checks++; if (sdata_a !== e.data) $display("FAIL sweep_data actual=%h required=%h", sdata_a, e.data); else n_pass++;
                n_checks++; if (cyc - last !== 4) $display("FAIL sweep_spacing actual=%0d required=4", cyc - last); else n_pass++;
                n_checks++; if (sdata_b !== e.data) $display("FAIL sweep_data_b actual=%h required=%h", sdata_b, e.data); else n_pass++;
                last = cyc;
            end
        end
        n_checks++; if (sb_q.size() != 0) $display("FAIL sweep_timeout actual=%0d pending required=0", sb_q.size()); else n_pass++;
        sb_q.delete();
        scan_en = 1'b0;
    endtask

    task automatic test_scan_write();
        exp_t e;
        bit   found;
        int   cyc;
        do_reset();
        scan_en = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            #1;
            if (svalid_a === 1'b1 && sidx_a === 3'd3) found = 1'b1;
        end
        n_checks++; if (!found) $display("FAIL scanwr_reach3 actual=absent required=step to 3"); else n_pass++;
        e.idx = 3'd4; e.data = 8'h99; sb_q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        we = 1'b1; wa = 3'd4; wd = 8'h99;
        @(negedge clk);
        #1;
        if (svalid_a === 1'b1) begin
            e = sb_q.pop_front();
            n_checks++; if (sidx_a !== e.idx) $display("FAIL scanwr_idx actual=%0d required=%0d", sidx_a, e.idx); else n_pass++;
            n_checks++; if (sdata_a !== e.data) $display("FAIL scanwr_data actual=%h required=%h", sdata_a, e.data); else n_pass++;
            n_checks++; if (sdata_b !== e.data) $display("FAIL scanwr_data_b actual=%h required=%h", sdata_b, e.data); else n_pass++;
        end else begin
            n_checks++;
            $display("FAIL scanwr_valid actual=%b required=1", svalid_a);
        end
        sb_q.delete();
        // Later write to the presented register must not leak into oScanData.
        wd = 8'h55; scan_en = 1'b0; ra1 = 3'd4;
        @(negedge clk);
        we = 1'b0;
        #1;
        n_checks++; if (rd1_b !== 8'h55) $display("FAIL hold_reg4 actual=%h required=55", rd1_b); else n_pass++;
        for (int t = 0; t < 3; t++) begin
            n_checks++; if (svalid_a !== 1'b0) $display("FAIL hold_valid actual=%b required=0", svalid_a); else n_pass++;
            n_checks++; if (sidx_a !== 3'd4) $display("FAIL hold_idx actual=%0d required=4", sidx_a); else n_pass++;
            n_checks++; if (sdata_a !== 8'h99) $display("FAIL hold_data actual=%h required=99", sdata_a); else n_pass++;
            @(negedge clk);
            #1;
        end
        write_reg(3'd5, 8'h5A);
        e.idx = 3'd5; e.data = 8'h5A; sb_q.push_back(e);
        scan_en = 1'b1;
        cyc = 0; found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            #1;
            cyc++;
            if (svalid_a === 1'b1) begin
                found = 1'b1;
                e = sb_q.pop_front();
                n_checks++; if (cyc !== 4) $display("FAIL resume_latency actual=%0d required=4", cyc); else n_pass++;
                n_checks++; if (sidx_a !== e.idx) $display("FAIL resume_idx actual=%0d required=%0d", sidx_a, e.idx); else n_pass++;
                n_checks++; if (sdata_a !== e.data) $display("FAIL resume_data actual=%h required=%h", sdata_a, e.data); else n_pass++;
            end
        end
        n_checks++; if (!found) $display("FAIL resume_timeout actual=no step required=step"); else n_pass++;
        sb_q.delete();
        scan_en = 1'b0;
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        for (int i = 1; i < 8; i++) write_reg(3'(i), 8'(i * 16));
        ra1 = 3'd6; ra2 = 3'd3;
        scan_en = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            #1;
            if (svalid_a === 1'b1 && sidx_a === 3'd6) found = 1'b1;
        end
        n_checks++; if (!found) $display("FAIL arst_reach6 actual=absent required=step to 6"); else n_pass++;
        n_checks++; if (rd1_a !== 8'h60) $display("FAIL arst_pre_rd1 actual=%h required=60", rd1_a); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (sidx_a !== 3'd0) $display("FAIL arst_idx actual=%0d required=0", sidx_a); else n_pass++;
        n_checks++; if (sdata_a !== 8'h00) $display("FAIL arst_data actual=%h required=00", sdata_a); else n_pass++;
        n_checks++; if (svalid_a !== 1'b0) $display("FAIL arst_valid actual=%b required=0", svalid_a); else n_pass++;
        n_checks++; if (rd1_a !== 8'h00) $display("FAIL arst_rd1 actual=%h required=00", rd1_a); else n_pass++;
        n_checks++; if (rd2_a !== 8'h00) $display("FAIL arst_rd2 actual=%h required=00", rd2_a); else n_pass++;
        n_checks++; if (rd1_b !== 8'h00) $display("FAIL arst_rd1_b actual=%h required=00", rd1_b); else n_pass++;
        n_checks++; if (svalid_c !== 1'b0) $display("FAIL arst_valid_c actual=%b required=0", svalid_c); else n_pass++;
        scan_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scan_sweep();
        test_scan_write();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
